// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order PC requests, credit-limited prefetch queue, one instruction per cycle out.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue loads the output register directly.

module fetch_unit_chk #(
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  input  logic              chng2nop,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0]       NOP      = 32'h0000_0013;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-3){1'b0}}, 3'b100};

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] rsp_pc_r;
  logic [31:0]       q_data_r [DEPTH];
  logic [ADDR_W-1:0] q_pc_r   [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  outst_r;
  logic [CNT_W-1:0]  discard_r;
  logic [31:0]       out_data_r;
  logic [ADDR_W-1:0] out_pc_r;
  logic              out_valid_r;

  logic              credit_ok_s;
  logic              req_valid_s;
  logic              accept_s;
  logic              keep_s;
  logic              advance_s;
  logic              pop_s;
  logic              push_s;
  logic              bypass_s;
  logic              full_s;
  logic [CNT_W-1:0]  outst_next_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [31:0]       out_data_s;
  logic [ADDR_W-1:0] out_pc_s;
  logic              out_valid_s;

  // Outstanding requests plus buffered words never exceed DEPTH, so the queue cannot overflow.
  assign credit_ok_s  = ({1'b0, outst_r} + {1'b0, count_r}) < {1'b0, DEPTH_C};
  assign req_valid_s  = ~rst & ~redirect_valid & credit_ok_s;
  assign accept_s     = req_valid_s & imem_req_ready;
  assign keep_s       = imem_rsp_valid & (discard_r == CNT_ZERO);
  assign advance_s    = ~redirect_valid & ~stall & ~chng2nop;
  assign pop_s        = advance_s & (count_r != CNT_ZERO);
`ifdef FETCH_BYPASS_EN
  assign bypass_s     = advance_s & (count_r == CNT_ZERO) & keep_s;
`else
  assign bypass_s     = 1'b0;
`endif
  assign push_s       = ~redirect_valid & keep_s & ~bypass_s;
  assign full_s       = (count_r == DEPTH_C);
  assign outst_next_s = outst_r + (accept_s ? CNT_ONE : CNT_ZERO) - (imem_rsp_valid ? CNT_ONE : CNT_ZERO);
  assign count_next_s = count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign instr_out      = out_data_r;
  assign instr_pc       = out_pc_r;
  assign instr_valid    = out_valid_r;

  // Next value of the output register, by redirect > stall > bubble > pop/bypass > NOP priority.
  always_comb begin
    out_data_s  = out_data_r;
    out_pc_s    = out_pc_r;
    out_valid_s = out_valid_r;
    if (redirect_valid) begin
      out_data_s  = NOP;
      out_pc_s    = {ADDR_W{1'b0}};
      out_valid_s = 1'b0;
    end else if (stall) begin
      out_data_s  = out_data_r;
      out_pc_s    = out_pc_r;
      out_valid_s = out_valid_r;
    end else if (pop_s) begin
      out_data_s  = q_data_r[head_r];
      out_pc_s    = q_pc_r[head_r];
      out_valid_s = 1'b1;
    end else if (bypass_s) begin
      out_data_s  = imem_rsp_data;
      out_pc_s    = rsp_pc_r;
      out_valid_s = 1'b1;
    end else begin
      out_data_s  = NOP;
      out_pc_s    = out_pc_r;
      out_valid_s = 1'b0;
    end
  end

  // Control state: PCs, pointers, counters and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      rsp_pc_r    <= RESET_PC;
      head_r      <= PTR_ZERO;
      tail_r      <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      outst_r     <= CNT_ZERO;
      discard_r   <= CNT_ZERO;
      out_data_r  <= NOP;
      out_pc_r    <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_s;
      out_pc_r    <= out_pc_s;
      out_valid_r <= out_valid_s;
      outst_r     <= outst_next_s;
      if (redirect_valid) begin
        // Everything still in flight belongs to the abandoned path.
        pc_r      <= redirect_pc;
        rsp_pc_r  <= redirect_pc;
        head_r    <= PTR_ZERO;
        tail_r    <= PTR_ZERO;
        count_r   <= CNT_ZERO;
        discard_r <= outst_next_s;
      end else begin
        if (accept_s) begin
          pc_r <= pc_r + PC_STEP;
        end
        if (push_s | bypass_s) begin
          rsp_pc_r <= rsp_pc_r + PC_STEP;
        end
        if (imem_rsp_valid && (discard_r != CNT_ZERO)) begin
          discard_r <= discard_r - CNT_ONE;
        end
        if (push_s) begin
          tail_r <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
        count_r <= count_next_s;
      end
    end
  end

  // Queue storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_data_r[tail_r] <= imem_rsp_data;
      q_pc_r[tail_r]   <= rsp_pc_r;
    end
  end

  fetch_unit_chk #(.CNT_W(CNT_W)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .full (full_s)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, queue-based reference model,
// directed corner sequences and a table of randomized traffic phases.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        chng2nop;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .chng2nop(chng2nop),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // stimulus knobs
  logic        s_rst, s_ready, s_stall, s_chng, s_redir;
  logic [31:0] s_redir_pc;
  int          rsp_pct;

  // memory: addresses of accepted requests, answered strictly in order
  logic [31:0] mem_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  // reference model
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc, m_rsp_pc, m_out, m_out_pc;
  logic        m_out_v;
  int          m_outst, m_disc;

  task automatic tick();
    logic rsp, m_rv, acc, keep, dut_acc;
    logic [31:0] rdata, dut_addr;
    int new_outst;
    ent_t e;
    rsp   = !s_rst && (mem_q.size() > 0) && ($urandom_range(99) < rsp_pct);
    rdata = rsp ? word_of(mem_q[0]) : $urandom;
    rst = s_rst; imem_req_ready = s_ready; imem_rsp_valid = rsp; imem_rsp_data = rdata;
    redirect_valid = s_redir; redirect_pc = s_redir_pc; stall = s_stall; chng2nop = s_chng;
    #1;
    m_rv = !s_rst && !s_redir && ((m_outst + m_q.size()) < DEPTH);
    check("req_valid", {63'd0, imem_req_valid}, {63'd0, m_rv});
    if (m_rv) check("req_addr", {32'd0, imem_req_addr}, {32'd0, m_pc});
    dut_acc  = imem_req_valid && imem_req_ready;
    dut_addr = imem_req_addr;
    if (s_rst) begin
      m_q.delete(); m_pc = 32'h0; m_rsp_pc = 32'h0; m_out = NOP; m_out_pc = 32'h0; m_out_v = 1'b0;
      m_outst = 0; m_disc = 0;
    end else begin
      acc       = m_rv && s_ready;
      new_outst = m_outst + (acc ? 1 : 0) - (rsp ? 1 : 0);
      keep      = rsp && (m_disc == 0);
      if (rsp && m_disc > 0) m_disc--;
      m_outst = new_outst;
      if (s_redir) begin
        m_pc = s_redir_pc; m_q.delete(); m_out = NOP; m_out_pc = 32'h0; m_out_v = 1'b0;
        m_disc = new_outst; m_rsp_pc = s_redir_pc;
      end else begin
        if (acc) m_pc += 32'd4;
        if (s_stall) begin
        end else if (s_chng) begin
          m_out = NOP; m_out_v = 1'b0;
        end else if (m_q.size() > 0) begin
          e = m_q.pop_front(); m_out = e.d; m_out_pc = e.pc; m_out_v = 1'b1;
`ifdef FETCH_BYPASS_EN
        end else if (keep) begin
          m_out = rdata; m_out_pc = m_rsp_pc; m_out_v = 1'b1; m_rsp_pc += 32'd4; keep = 1'b0;
`endif
        end else begin
          m_out = NOP; m_out_v = 1'b0;
        end
        if (keep) begin
          e.d = rdata; e.pc = m_rsp_pc;
          m_q.push_back(e);
          m_rsp_pc += 32'd4;
        end
      end
    end
    @(posedge clk);
    if (s_rst) mem_q.delete();
    else begin
      if (rsp) void'(mem_q.pop_front());
      if (dut_acc) mem_q.push_back(dut_addr);
    end
    @(negedge clk);
    check("instr_valid", {63'd0, instr_valid}, {63'd0, m_out_v});
    check("instr_pc", {32'd0, instr_pc}, {32'd0, m_out_pc});
    check("instr_out", {32'd0, instr_out}, {32'd0, m_out});
  endtask

  typedef struct {
    int cycles; int ready_pct; int rsp_pct; int stall_pct; int chng_pct; int redir_pct; int rst_pct;
  } phase_t;
  phase_t phases[5];

  int          lat;
  logic [31:0] held, held_pc, pc0;
  logic        seen;

  initial begin
    phases[0] = '{cycles: 300, ready_pct: 100, rsp_pct: 100, stall_pct: 10, chng_pct: 10, redir_pct: 3, rst_pct: 0};
    phases[1] = '{cycles: 300, ready_pct: 60,  rsp_pct: 50,  stall_pct: 20, chng_pct: 10, redir_pct: 5, rst_pct: 0};
    phases[2] = '{cycles: 300, ready_pct: 90,  rsp_pct: 30,  stall_pct: 40, chng_pct: 5,  redir_pct: 2, rst_pct: 0};
    phases[3] = '{cycles: 300, ready_pct: 70,  rsp_pct: 80,  stall_pct: 15, chng_pct: 15, redir_pct: 8, rst_pct: 2};
    phases[4] = '{cycles: 200, ready_pct: 30,  rsp_pct: 90,  stall_pct: 5,  chng_pct: 5,  redir_pct: 1, rst_pct: 0};

    s_rst = 1'b1; s_ready = 1'b1; s_stall = 1'b0; s_chng = 1'b0; s_redir = 1'b0; s_redir_pc = 32'h0;
    rsp_pct = 100;
    tick(); tick();
    check("rst_instr_out", {32'd0, instr_out}, {32'd0, NOP});
    check("rst_instr_pc", {32'd0, instr_pc}, 64'd0);
    check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);

    // first request right after reset release
    s_rst = 1'b0; rst = 1'b0;
    #1;
    check("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("first_req_addr", {32'd0, imem_req_addr}, 64'd0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); lat++;
      if (instr_valid) break;
    end
`ifdef FETCH_BYPASS_EN
    check("first_latency", 64'(lat), 64'd2);
`else
    check("first_latency", 64'(lat), 64'd3);
`endif
    check("first_pc", {32'd0, instr_pc}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", {63'd0, instr_valid}, 64'd1);
      check("stream_pc", {32'd0, instr_pc}, 64'(4 * (i + 1)));
    end

    // stall: output frozen, then resumes without gap
    held = instr_out; held_pc = instr_pc;
    s_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_data", {32'd0, instr_out}, {32'd0, word_of(32'd32)});
      check("stall_hold_pc", {32'd0, instr_pc}, 64'd32);
    end
    s_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("resume_pc", {32'd0, instr_pc}, {32'd0, held_pc + 32'(4 * (i + 1))});
      check("resume_valid", {63'd0, instr_valid}, 64'd1);
    end

    // one-cycle bubble, then the held instruction
    held_pc = instr_pc;
    s_chng = 1'b1; tick();
    check("bubble_valid", {63'd0, instr_valid}, 64'd0);
    check("bubble_out", {32'd0, instr_out}, {32'd0, NOP});
    s_chng = 1'b0; tick();
    check("after_bubble_pc", {32'd0, instr_pc}, {32'd0, held_pc + 32'd4});

    // redirect with requests in flight
    rsp_pct = 0;
    for (int i = 0; i < 4; i++) tick();
    s_redir = 1'b1; s_redir_pc = 32'h100; tick();
    s_redir = 1'b0; rsp_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid) begin seen = 1'b1; break; end
    end
    check("redirect_seen", {63'd0, seen}, 64'd1);
    check("redirect_pc", {32'd0, instr_pc}, 64'h100);

    // memory not ready: address stable, output drains to NOPs
    pc0 = m_pc;
    s_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("addr_stable", {32'd0, imem_req_addr}, {32'd0, pc0});
    end
    check("drained_valid", {63'd0, instr_valid}, 64'd0);
    s_ready = 1'b1;

    // randomized traffic phases
    for (int p = 0; p < 5; p++) begin
      rsp_pct = phases[p].rsp_pct;
      for (int c = 0; c < phases[p].cycles; c++) begin
        s_ready = ($urandom_range(99) < phases[p].ready_pct);
        s_stall = ($urandom_range(99) < phases[p].stall_pct);
        s_chng  = ($urandom_range(99) < phases[p].chng_pct);
        s_redir = ($urandom_range(99) < phases[p].redir_pct);
        s_rst   = ($urandom_range(99) < phases[p].rst_pct);
        s_redir_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
        tick();
      end
    end
    s_rst = 1'b0; s_stall = 1'b0; s_chng = 1'b0; s_redir = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
